// File: rtl/sqrt_controller.sv
// Sequencing FSM for the 5-bit sqrt(a^2+b^2) approximation datapath: one micro-step per clock.
// Optional macro SQRT_CTRL_DONE_HOLD_EN holds DONE until ack; undefined, DONE lasts one cycle.
module sqrt_controller (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       In1_tri,
    output logic       In2_tri,
    output logic       R1_e,
    output logic       R2_e,
    output logic       R1_tri,
    output logic       R2_tri,
    output logic       AU1_tri,
    output logic       AU1_tri1,
    output logic [1:0] AU1_op,
    output logic       shift3_tri,
    output logic       R3_e,
    output logic       R4_e,
    output logic       R5_e,
    output logic       R4_tri,
    output logic       R5_tri,
    output logic       AU2_tri,
    output logic [1:0] AU2_op
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LOAD = 4'd1,
        ST_ABS1 = 4'd2,
        ST_ABS2 = 4'd3,
        ST_MAX  = 4'd4,
        ST_MIN  = 4'd5,
        ST_SUB  = 4'd6,
        ST_ADD  = 4'd7,
        ST_MAXF = 4'd8,
        ST_DONE = 4'd9
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       in1_tri;
        logic       in2_tri;
        logic       r1_e;
        logic       r2_e;
        logic       r1_tri;
        logic       r2_tri;
        logic       au1_tri;
        logic       au1_tri1;
        logic [1:0] au1_op;
        logic       shift3_tri;
        logic       r3_e;
        logic       r4_e;
        logic       r5_e;
        logic       r4_tri;
        logic       r5_tri;
        logic       au2_tri;
        logic [1:0] au2_op;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = ctrl_t'(21'd0);

    state_t state_r;
    state_t state_nxt_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_nxt_s;

    // Control vector for a state; the registered copy makes outputs a function of state only.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = CTRL_OFF;
        case (s)
            ST_IDLE: c = CTRL_OFF;
            ST_LOAD: begin
                c.in2_tri = 1'b1; c.r1_e = 1'b1;
                c.in1_tri = 1'b1; c.r2_e = 1'b1;
            end
            ST_ABS1: begin
                c.au1_op = 2'b00; c.r2_tri = 1'b1; c.au1_tri = 1'b1; c.r1_e = 1'b1;
            end
            ST_ABS2: begin
                c.au1_op = 2'b01; c.r2_tri = 1'b1; c.au1_tri1 = 1'b1; c.r2_e = 1'b1;
            end
            ST_MAX: begin
                c.au1_op = 2'b11; c.r2_tri = 1'b1; c.r4_e = 1'b1;
                c.shift3_tri = 1'b1; c.r3_e = 1'b1;
            end
            ST_MIN: begin
                c.au1_op = 2'b10; c.r2_tri = 1'b1; c.r5_e = 1'b1;
            end
            ST_SUB: begin
                c.r4_tri = 1'b1; c.au2_op = 2'b01; c.au2_tri = 1'b1; c.r3_e = 1'b1;
            end
            ST_ADD: begin
                c.r5_tri = 1'b1; c.au2_op = 2'b00; c.au2_tri = 1'b1; c.r3_e = 1'b1;
            end
            ST_MAXF: begin
                c.r4_tri = 1'b1; c.au2_op = 2'b10; c.au2_tri = 1'b1; c.r3_e = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
            default: c = CTRL_OFF;
        endcase
        if (s != ST_IDLE) begin
            c.busy = 1'b1;
        end else begin
            c.busy = 1'b0;
        end
        return c;
    endfunction

    // Next-state sequencing; start only matters in IDLE, illegal encodings recover to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_ABS1;
            ST_ABS1: state_nxt_s = ST_ABS2;
            ST_ABS2: state_nxt_s = ST_MAX;
            ST_MAX:  state_nxt_s = ST_MIN;
            ST_MIN:  state_nxt_s = ST_SUB;
            ST_SUB:  state_nxt_s = ST_ADD;
            ST_ADD:  state_nxt_s = ST_MAXF;
            ST_MAXF: state_nxt_s = ST_DONE;
            ST_DONE: begin
`ifdef SQRT_CTRL_DONE_HOLD_EN
                if (ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

`ifndef SQRT_CTRL_DONE_HOLD_EN
    logic ack_unused_s;
    assign ack_unused_s = ack;
`endif

    // Decode the upcoming state so the registered outputs line up with state_r.
    always_comb begin
        ctrl_nxt_s = decode(state_nxt_s);
    end

    // State and output registers; clear abandons any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
            ctrl_r  <= CTRL_OFF;
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign busy       = ctrl_r.busy;
    assign done       = ctrl_r.done;
    assign In1_tri    = ctrl_r.in1_tri;
    assign In2_tri    = ctrl_r.in2_tri;
    assign R1_e       = ctrl_r.r1_e;
    assign R2_e       = ctrl_r.r2_e;
    assign R1_tri     = ctrl_r.r1_tri;
    assign R2_tri     = ctrl_r.r2_tri;
    assign AU1_tri    = ctrl_r.au1_tri;
    assign AU1_tri1   = ctrl_r.au1_tri1;
    assign AU1_op     = ctrl_r.au1_op;
    assign shift3_tri = ctrl_r.shift3_tri;
    assign R3_e       = ctrl_r.r3_e;
    assign R4_e       = ctrl_r.r4_e;
    assign R5_e       = ctrl_r.r5_e;
    assign R4_tri     = ctrl_r.r4_tri;
    assign R5_tri     = ctrl_r.r5_tri;
    assign AU2_tri    = ctrl_r.au2_tri;
    assign AU2_op     = ctrl_r.au2_op;

endmodule
